bus_sched: RTL and testbench

BUS_SCHED -- requirements
Module: bus_sched

---
 rtl/bus_sched.sv | 207 ++++++++++++++++++++
 tb/tb_bus_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_sched.sv
// bus_sched: six-requester shared-bus scheduler.
// Priority is console, then UBA1..UBA4 in round-robin order, then CPU.
// A starvation guard lets the CPU win after too many non-CPU grants.
// Each granted cycle waits for busACKI; if none arrives it ends as NXM.
module bus_sched #(
  parameter int TIMEOUT = 127,
  parameter int STARVE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:5] reqI,
  output logic [0:5] gntO,
  output logic       busREQO,
  input  logic       busACKI,
  output logic [0:5] ackO,
  output logic [0:5] nxmO,
  output logic       nxmFlagO,
  output logic [2:0] nxmIdO,
  input  logic       nxmClrI
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] LP_STARVE  = 4'(STARVE);

  state_t     r_state;
  logic [0:5] r_gnt;
  logic [0:5] r_ack;
  logic [0:5] r_nxm;
  logic       r_flag;
  logic [2:0] r_id;
  logic [2:0] r_win;
  logic [7:0] r_cnt;
  logic [3:0] r_starve;
  logic [1:0] r_rr;

  state_t     w_state_nx;
  logic [0:5] w_gnt_nx;
  logic [0:5] w_ack_nx;
  logic [0:5] w_nxm_nx;
  logic [2:0] w_win_nx;
  logic [7:0] w_cnt_nx;
  logic [3:0] w_starve_nx;
  logic [1:0] w_rr_nx;
  logic       w_set_nxm;
  logic       w_any;
  logic [2:0] w_pick;
  logic [1:0] w_cand;
  logic       w_uba_hit;
  logic [2:0] w_uba_idx;
  logic       w_win_req;

  // Requester index to one-hot vector in the [0:5] bit order.
  function automatic logic [0:5] f_onehot(input logic [2:0] idx);
    case (idx)
      3'd0:    f_onehot = 6'b100000;
      3'd1:    f_onehot = 6'b010000;
      3'd2:    f_onehot = 6'b001000;
      3'd3:    f_onehot = 6'b000100;
      3'd4:    f_onehot = 6'b000010;
      3'd5:    f_onehot = 6'b000001;
      default: f_onehot = 6'b000000;
    endcase
  endfunction

  assign w_any     = |reqI;
  assign w_win_req = reqI[r_win];

  // Arbitration: starved CPU, console, round-robin UBA, then CPU.
  always_comb begin
    w_uba_hit = 1'b0;
    w_uba_idx = 3'd1;
    w_cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_rr + 2'(k);
      if (!w_uba_hit && reqI[3'd1 + 3'(w_cand)]) begin
        w_uba_hit = 1'b1;
        w_uba_idx = 3'd1 + 3'(w_cand);
      end else begin
        w_uba_hit = w_uba_hit;
      end
    end
    if (reqI[5] && (r_starve >= LP_STARVE)) begin
      w_pick = 3'd5;
    end else if (reqI[0]) begin
      w_pick = 3'd0;
    end else if (w_uba_hit) begin
      w_pick = w_uba_idx;
    end else begin
      w_pick = 3'd5;
    end
  end

  // State and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= 6'b000000;
      r_ack    <= 6'b000000;
      r_nxm    <= 6'b000000;
      r_flag   <= 1'b0;
      r_id     <= 3'd0;
      r_win    <= 3'd0;
      r_cnt    <= 8'd0;
      r_starve <= 4'd0;
      r_rr     <= 2'd3;
    end else begin
      r_state  <= w_state_nx;
      r_gnt    <= w_gnt_nx;
      r_ack    <= w_ack_nx;
      r_nxm    <= w_nxm_nx;
      r_win    <= w_win_nx;
      r_cnt    <= w_cnt_nx;
      r_starve <= w_starve_nx;
      r_rr     <= w_rr_nx;
      if (w_set_nxm) begin
        r_flag <= 1'b1;
        r_id   <= r_win;
      end else if (nxmClrI) begin
        r_flag <= 1'b0;
      end
    end
  end

  // Next-state: a dropped request aborts, ACK beats the timeout.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nx = S_BUSY;
        else       w_state_nx = S_IDLE;
      end
      S_BUSY: begin
        if (!w_win_req)                w_state_nx = S_IDLE;
        else if (busACKI)              w_state_nx = S_DONE;
        else if (r_cnt == LP_TO_LAST)  w_state_nx = S_DONE;
        else                           w_state_nx = S_BUSY;
      end
      S_DONE: begin
        if (!w_win_req) w_state_nx = S_IDLE;
        else            w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next values for grant, pulses, counters.
  always_comb begin
    w_gnt_nx    = r_gnt;
    w_ack_nx    = 6'b000000;
    w_nxm_nx    = 6'b000000;
    w_win_nx    = r_win;
    w_cnt_nx    = r_cnt;
    w_rr_nx     = r_rr;
    w_set_nxm   = 1'b0;
    w_starve_nx = reqI[5] ? r_starve : 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nx = f_onehot(w_pick);
          w_win_nx = w_pick;
          w_cnt_nx = 8'd0;
          if ((w_pick >= 3'd1) && (w_pick <= 3'd4)) w_rr_nx = 2'(w_pick - 3'd1);
          else                                      w_rr_nx = r_rr;
          if (w_pick == 3'd5)                       w_starve_nx = 4'd0;
          else if (reqI[5] && (r_starve != 4'd15))  w_starve_nx = r_starve + 4'd1;
          else if (reqI[5])                         w_starve_nx = r_starve;
          else                                      w_starve_nx = 4'd0;
        end else begin
          w_gnt_nx = 6'b000000;
        end
      end
      S_BUSY: begin
        if (!w_win_req) begin
          w_gnt_nx = 6'b000000;
        end else if (busACKI) begin
          w_ack_nx = f_onehot(r_win);
        end else if (r_cnt == LP_TO_LAST) begin
          w_nxm_nx  = f_onehot(r_win);
          w_set_nxm = 1'b1;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nx = r_cnt + 8'd1;
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_DONE: begin
        if (!w_win_req) w_gnt_nx = 6'b000000;
        else            w_gnt_nx = r_gnt;
      end
      default: w_gnt_nx = 6'b000000;
    endcase
  end

  assign gntO     = r_gnt;
  assign busREQO  = (r_state == S_BUSY);
  assign ackO     = r_ack;
  assign nxmO     = r_nxm;
  assign nxmFlagO = r_flag;
  assign nxmIdO   = r_id;

endmodule

// File: tb/tb_bus_sched.sv
// tb_bus_sched: directed vectors with hand-computed expectations for bus_sched.
module tb_bus_sched;

  localparam int TO = 127;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:5] reqI;
  logic [0:5] gntO;
  logic       busREQO;
  logic       busACKI;
  logic [0:5] ackO;
  logic [0:5] nxmO;
  logic       nxmFlagO;
  logic [2:0] nxmIdO;
  logic       nxmClrI;

  int n_vec = 0;
  int n_err = 0;

  bus_sched #(.TIMEOUT(TO), .STARVE(8)) dut (
    .clk(clk), .rst(rst), .reqI(reqI), .gntO(gntO), .busREQO(busREQO),
    .busACKI(busACKI), .ackO(ackO), .nxmO(nxmO), .nxmFlagO(nxmFlagO),
    .nxmIdO(nxmIdO), .nxmClrI(nxmClrI)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant to appear; lands on the first grant cycle.
  task automatic wait_gnt(input string tag, output logic [0:5] g);
    int k;
    k = 0;
    while (gntO == 6'b000000 && k < 20) begin
      tick();
      k++;
    end
    check_val({tag, "_gnt_seen"}, 32'(gntO != 6'b000000), 32'd1);
    g = gntO;
  endtask

  // One acknowledged transfer: grant, ACK, ackO pulse, release, idle gap.
  task automatic serve(input string tag, input logic [0:5] exp_g);
    logic [0:5] g;
    logic [0:5] saved;
    wait_gnt(tag, g);
    check_val({tag, "_gnt"}, 32'(g), 32'(exp_g));
    check_val({tag, "_busreq"}, 32'(busREQO), 32'd1);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    check_val({tag, "_ack"}, 32'(ackO), 32'(exp_g));
    check_val({tag, "_busreq_done"}, 32'(busREQO), 32'd0);
    saved = reqI;
    reqI  = reqI & ~g;
    tick();
    check_val({tag, "_gap"}, 32'(gntO), 32'd0);
    reqI = saved;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [0:5] g;
    logic [0:5] rr_exp [5];
    int k;
    rr_exp[0] = 6'b010000;
    rr_exp[1] = 6'b001000;
    rr_exp[2] = 6'b000100;
    rr_exp[3] = 6'b000010;
    rr_exp[4] = 6'b010000;

    rst = 1'b1; reqI = 6'b000000; busACKI = 1'b0; nxmClrI = 1'b0;
    tick(); tick();
    check_val("rst_gnt",  32'(gntO), 32'd0);
    check_val("rst_busreq", 32'(busREQO), 32'd0);
    check_val("rst_ack",  32'(ackO), 32'd0);
    check_val("rst_nxm",  32'(nxmO), 32'd0);
    check_val("rst_flag", 32'(nxmFlagO), 32'd0);
    check_val("rst_id",   32'(nxmIdO), 32'd0);
    rst = 1'b0;
    tick();

    // Round-robin over all four UBAs: 1,2,3,4,1.
    reqI = 6'b011110;
    for (int i = 0; i < 5; i++) serve("rr", rr_exp[i]);
    reqI = 6'b000000;
    tick();

    // Console beats CPU; CPU follows after console release and one idle cycle.
    reqI = 6'b100001;
    wait_gnt("con", g);
    check_val("con_gnt", 32'(g), 32'(6'b100000));
    tick();
    tick();
    check_val("con_noack", 32'(ackO), 32'd0);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    check_val("con_ack", 32'(ackO), 32'(6'b100000));
    check_val("con_hold", 32'(gntO), 32'(6'b100000));
    reqI = 6'b000001;
    tick();
    check_val("con_gap", 32'(gntO), 32'd0);
    tick();
    check_val("cpu_gnt", 32'(gntO), 32'(6'b000001));
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    check_val("cpu_ack", 32'(ackO), 32'(6'b000001));
    reqI = 6'b000000;
    tick();

    // Starvation guard: 8 UBA1 grants then CPU, twice.
    reqI = 6'b010001;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) serve("starve_uba", 6'b010000);
      serve("starve_cpu", 6'b000001);
    end
    reqI = 6'b000000;
    tick();

    // CPU cycle with no ACK ends as NXM.
    reqI = 6'b000001;
    wait_gnt("nxm", g);
    check_val("nxm_gnt", 32'(g), 32'(6'b000001));
    k = 0;
    while (nxmO == 6'b000000 && k < 300) begin
      tick();
      k++;
    end
    check_val("nxm_lat",  32'(k), 32'(TO));
    check_val("nxm_pulse", 32'(nxmO), 32'(6'b000001));
    check_val("nxm_noack", 32'(ackO), 32'd0);
    check_val("nxm_flag", 32'(nxmFlagO), 32'd1);
    check_val("nxm_id",   32'(nxmIdO), 32'd5);
    tick();
    check_val("nxm_once", 32'(nxmO), 32'd0);
    check_val("nxm_busreq", 32'(busREQO), 32'd0);
    nxmClrI = 1'b1;
    reqI = 6'b000000;
    tick();
    nxmClrI = 1'b0;
    check_val("nxm_clr_flag", 32'(nxmFlagO), 32'd0);
    check_val("nxm_clr_id",   32'(nxmIdO), 32'd5);

    // ACK on the last count cycle wins over timeout.
    reqI = 6'b001000;
    wait_gnt("late", g);
    check_val("late_gnt", 32'(g), 32'(6'b001000));
    repeat (126) tick();
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    check_val("late_ack",  32'(ackO), 32'(6'b001000));
    check_val("late_nonxm", 32'(nxmO), 32'd0);
    check_val("late_flag", 32'(nxmFlagO), 32'd0);
    reqI = 6'b000000;
    tick();

    // UBA2 drops mid-BUSY: abort even with ACK present.
    reqI = 6'b001000;
    wait_gnt("abort", g);
    tick();
    tick();
    reqI = 6'b000000;
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    check_val("abort_gnt", 32'(gntO), 32'd0);
    check_val("abort_busreq", 32'(busREQO), 32'd0);
    check_val("abort_ack", 32'(ackO), 32'd0);
    check_val("abort_nxm", 32'(nxmO), 32'd0);

    // Async reset mid-BUSY, then the pointer restarts at UBA1.
    reqI = 6'b011000;
    wait_gnt("arst", g);
    check_val("arst_first", 32'(g), 32'(6'b010000));
    tick();
    #2 rst = 1'b1;
    #1;
    check_val("arst_busreq", 32'(busREQO), 32'd0);
    check_val("arst_gnt",    32'(gntO), 32'd0);
    check_val("arst_id",     32'(nxmIdO), 32'd0);
    #1 rst = 1'b0;
    tick();
    check_val("arst_next", 32'(gntO), 32'(6'b010000));
    reqI = 6'b000000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
